// File: rtl/sys_row_pipe.sv
// One row of a systolic MAC array: operands flow left-to-right and top-to-bottom,
// each PE accumulates with saturation, and a double-buffered snapshot is read out
// serially over a valid/ready port while the next tile keeps accumulating.
module sys_row_pipe #(
    parameter int NUM_PE = 16,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_left_tot,
    input  logic                     in_left_vld,
    input  logic [DATA_W*NUM_PE-1:0] in_up_tot,
    input  logic [NUM_PE-1:0]        in_up_vld,
    output logic [DATA_W*NUM_PE-1:0] out_down_TT,
    output logic [NUM_PE-1:0]        out_down_vld,
    input  logic                     drain_start,
    output logic [ACC_W-1:0]         res_data,
    output logic                     res_vld,
    input  logic                     res_rdy,
    output logic                     busy,
    output logic                     drain_done,
    output logic [NUM_PE-1:0]        ovf
);

    localparam int IDX_W  = $clog2(NUM_PE);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t             r_state, w_state_next;
    logic [IDX_W-1:0]   r_idx, w_idx_next;
    logic               r_done, w_done_next;
    logic               w_snap;

    // Operand seen by each PE; PE0 takes the row input directly.
    logic [DATA_W-1:0]  w_left     [NUM_PE];
    logic               w_left_vld [NUM_PE];
    logic [DATA_W-1:0]  r_left     [NUM_PE-1];
    logic               r_left_vld [NUM_PE-1];

    logic [ACC_W-1:0]   r_acc  [NUM_PE];
    logic [ACC_W-1:0]   r_buf  [NUM_PE];
    logic               r_ovf  [NUM_PE];
    logic [DATA_W-1:0]  r_down [NUM_PE];
    logic               r_down_vld [NUM_PE];

    // Snapshot only happens from IDLE; a request during readout is dropped.
    assign w_snap = (r_state == S_IDLE) && drain_start;

    assign w_left[0]     = in_left_tot;
    assign w_left_vld[0] = in_left_vld;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PE - 1; gi++) begin : g_left
            // Left operand shift register: one stage between neighbouring PEs.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_left[gi]     <= '0;
                    r_left_vld[gi] <= 1'b0;
                end else begin
                    r_left[gi]     <= w_left[gi];
                    r_left_vld[gi] <= w_left_vld[gi];
                end
            end
            assign w_left[gi+1]     = r_left[gi];
            assign w_left_vld[gi+1] = r_left_vld[gi];
        end

        for (gi = 0; gi < NUM_PE; gi++) begin : g_pe
            logic              w_mac_en;
            logic [PROD_W-1:0] w_a, w_b, w_prod;
            logic [ACC_W:0]    w_base, w_sum;
            logic              w_sat;
            logic [ACC_W-1:0]  w_acc_next;

            assign w_mac_en = w_left_vld[gi] & in_up_vld[gi];
            // Operands are sign-extended so the low PROD_W bits of the product are the signed result.
            assign w_a      = {{DATA_W{w_left[gi][DATA_W-1]}}, w_left[gi]};
            assign w_b      = {{DATA_W{in_up_tot[gi*DATA_W+DATA_W-1]}}, in_up_tot[gi*DATA_W +: DATA_W]};
            assign w_prod   = w_a * w_b;
            // A MAC in the snapshot cycle starts the new tile from zero.
            assign w_base   = w_snap ? '0 : {r_acc[gi][ACC_W-1], r_acc[gi]};
            assign w_sum    = w_base + {{(ACC_W+1-PROD_W){w_prod[PROD_W-1]}}, w_prod};
            assign w_sat    = w_sum[ACC_W] ^ w_sum[ACC_W-1];

            // Clamp to the most positive / most negative accumulator value on overflow.
            always_comb begin
                w_acc_next = w_sum[ACC_W-1:0];
                if (w_sat) begin
                    w_acc_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                              : {1'b0, {(ACC_W-1){1'b1}}};
                end
            end

            // Per-PE state: accumulator, sticky overflow, drain buffer word, down pipeline.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc[gi]      <= '0;
                    r_buf[gi]      <= '0;
                    r_ovf[gi]      <= 1'b0;
                    r_down[gi]     <= '0;
                    r_down_vld[gi] <= 1'b0;
                end else begin
                    r_down[gi]     <= in_up_tot[gi*DATA_W +: DATA_W];
                    r_down_vld[gi] <= in_up_vld[gi];
                    if (w_snap) begin
                        r_buf[gi] <= r_acc[gi];
                    end
                    if (w_mac_en) begin
                        r_acc[gi] <= w_acc_next;
                    end else if (w_snap) begin
                        r_acc[gi] <= '0;
                    end
                    r_ovf[gi] <= (w_mac_en & w_sat) | (~w_snap & r_ovf[gi]);
                end
            end

            assign out_down_TT[gi*DATA_W +: DATA_W] = r_down[gi];
            assign out_down_vld[gi]                 = r_down_vld[gi];
            assign ovf[gi]                          = r_ovf[gi];
        end
    endgenerate

    // Readout state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_done  <= w_done_next;
        end
    end

    // Readout next-state: walk the buffer PE0 first, advancing on each accepted beat.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (drain_start) begin
                    w_state_next = S_DRAIN;
                    w_idx_next   = '0;
                end
            end
            S_DRAIN: begin
                if (res_rdy) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_next = S_IDLE;
                        w_idx_next   = '0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    assign busy       = (r_state == S_DRAIN);
    assign res_vld    = busy;
    assign res_data   = busy ? r_buf[r_idx] : '0;
    assign drain_done = r_done;

endmodule

// File: tb/tb_sys_row_pipe.sv
// Bench for sys_row_pipe: 4-PE row, 8-bit operands, 16-bit accumulators.
module tb_sys_row_pipe;

    localparam int NP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_left_tot;
    logic        in_left_vld;
    logic [31:0] in_up_tot;
    logic [3:0]  in_up_vld;
    logic [31:0] out_down_TT;
    logic [3:0]  out_down_vld;
    logic        drain_start;
    logic [15:0] res_data;
    logic        res_vld;
    logic        res_rdy;
    logic        busy;
    logic        drain_done;
    logic [3:0]  ovf;

    int total = 0;
    int bad   = 0;
    logic [15:0] sb_q[$];

    typedef struct packed {
        logic [7:0]       left;
        logic [7:0]       n;
        logic [3:0][7:0]  up;
        logic [3:0]       vld;
        logic [3:0][15:0] exp;
        logic [3:0]       exp_ovf;
    } vec_t;

    vec_t vecs[6];

    sys_row_pipe #(.NUM_PE(NP), .DATA_W(8), .ACC_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_left_tot(in_left_tot), .in_left_vld(in_left_vld),
        .in_up_tot(in_up_tot), .in_up_vld(in_up_vld),
        .out_down_TT(out_down_TT), .out_down_vld(out_down_vld),
        .drain_start(drain_start),
        .res_data(res_data), .res_vld(res_vld), .res_rdy(res_rdy),
        .busy(busy), .drain_done(drain_done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Pop and compare n beats with res_rdy high, then check the done pulse.
    task automatic collect(input int n);
        int w;
        logic [15:0] e;
        res_rdy = 1'b1;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (!res_vld && w < 20) begin
                step();
                w++;
            end
            chk("res_vld", res_vld, 1);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hdead;
            $display("beat %0d data=%0h", k, res_data);
            chk("beat", res_data, e);
            step();
        end
        chk("done_pulse", drain_done, 1);
        chk("busy_fall", busy, 0);
        step();
        chk("done_once", drain_done, 0);
    endtask

    task automatic drain_full();
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        chk("ovf_clr", ovf, 0);
        chk("busy_rise", busy, 1);
        collect(NP);
    endtask

    // Stream one left value for n cycles while the up operands are held valid long enough
    // for every PE to see all n left values.
    task automatic feed(input logic [7:0] l, input int n, input logic [31:0] up, input logic [3:0] vld);
        in_up_tot   = up;
        in_up_vld   = vld;
        in_left_tot = l;
        in_left_vld = 1'b1;
        for (int c = 0; c < n; c++) begin
            step();
            if (c == 0) begin
                chk("down_tt", out_down_TT, up);
                chk("down_vld", out_down_vld, vld);
            end
        end
        in_left_vld = 1'b0;
        repeat (NP) step();
        in_up_vld = '0;
        step();
    endtask

    initial begin
        vecs[0] = '{left: 8'd3, n: 8'd4, up: {8'd2, 8'd2, 8'd2, 8'd2}, vld: 4'b1111,
                    exp: {16'd24, 16'd24, 16'd24, 16'd24}, exp_ovf: 4'b0000};
        vecs[1] = '{left: 8'd3, n: 8'd4, up: {8'd2, 8'd2, 8'd2, 8'd2}, vld: 4'b1011,
                    exp: {16'd24, 16'd0, 16'd24, 16'd24}, exp_ovf: 4'b0000};
        vecs[2] = '{left: 8'h80, n: 8'd3, up: {8'h80, 8'h80, 8'h80, 8'h80}, vld: 4'b1111,
                    exp: {16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff}, exp_ovf: 4'b1111};
        vecs[3] = '{left: 8'h80, n: 8'd3, up: {8'd127, 8'd127, 8'd127, 8'd127}, vld: 4'b1111,
                    exp: {16'h8000, 16'h8000, 16'h8000, 16'h8000}, exp_ovf: 4'b1111};
        vecs[4] = '{left: 8'd5, n: 8'd7, up: {8'hfd, 8'd10, 8'hff, 8'd1}, vld: 4'b1111,
                    exp: {16'hff97, 16'd350, 16'hffdd, 16'd35}, exp_ovf: 4'b0000};
        vecs[5] = '{left: 8'hff, n: 8'd2, up: {8'd64, 8'd127, 8'd0, 8'h80}, vld: 4'b0110,
                    exp: {16'd0, 16'hff02, 16'd0, 16'd0}, exp_ovf: 4'b0000};

        rst = 1'b1; in_left_tot = '0; in_left_vld = 1'b0; in_up_tot = '0; in_up_vld = '0;
        drain_start = 1'b0; res_rdy = 1'b0;
        repeat (3) step();
        chk("rst_res_vld", res_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_done", drain_done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_down", {out_down_TT, out_down_vld}, 0);
        rst = 1'b0;
        step();

        // Table-driven tiles: accumulate, check overflow flags, drain and score.
        for (int v = 0; v < 6; v++) begin
            feed(vecs[v].left, int'(vecs[v].n), vecs[v].up, vecs[v].vld);
            chk("ovf_pre", ovf, vecs[v].exp_ovf);
            for (int i = 0; i < NP; i++) sb_q.push_back(vecs[v].exp[i]);
            drain_full();
        end

        // Stall mid-drain with MACs running, ignored drain_start, back-to-back drain.
        feed(8'd1, 2, 32'h01010101, 4'b1111);
        for (int i = 0; i < NP; i++) sb_q.push_back(16'd2);
        drain_start = 1'b1;
        in_left_tot = 8'd4; in_left_vld = 1'b1;
        in_up_tot = 32'h00000005; in_up_vld = 4'b0001;
        step();
        drain_start = 1'b0; in_left_vld = 1'b0; in_up_vld = '0;
        res_rdy = 1'b1;
        chk("stall_beat0", res_data, sb_q.pop_front());
        step();
        res_rdy = 1'b0;
        in_left_tot = 8'd2; in_left_vld = 1'b1;
        in_up_tot = 32'h00000300; in_up_vld = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            chk("stall_data", res_data, sb_q[0]);
            chk("stall_busy", busy, 1);
            chk("stall_vld", res_vld, 1);
            drain_start = (c == 2);
            in_left_vld = (c < 3);
            step();
        end
        drain_start = 1'b0; in_left_vld = 1'b0; in_up_vld = '0;
        res_rdy = 1'b1;
        for (int k = 1; k < NP; k++) begin
            chk("stall_beat", res_data, sb_q.pop_front());
            step();
        end
        chk("b2b_done", drain_done, 1);
        chk("b2b_busy", busy, 0);
        sb_q.push_back(16'd20); sb_q.push_back(16'd18);
        sb_q.push_back(16'd0);  sb_q.push_back(16'd0);
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        chk("b2b_accept", busy, 1);
        collect(NP);

        // Reset in the middle of a readout.
        feed(8'd1, 3, {8'd4, 8'd3, 8'd2, 8'd1}, 4'b1111);
        sb_q.push_back(16'd3); sb_q.push_back(16'd6);
        sb_q.push_back(16'd9); sb_q.push_back(16'd12);
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        res_rdy = 1'b1;
        in_left_tot = 8'd7; in_left_vld = 1'b1;
        in_up_tot = 32'h00000001; in_up_vld = 4'b0001;
        chk("rb_beat0", res_data, sb_q.pop_front());
        step();
        in_left_vld = 1'b0; in_up_vld = '0;
        chk("rb_beat1", res_data, sb_q.pop_front());
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        res_rdy = 1'b0;
        chk("rb_busy", busy, 1);
        chk("rb_beat2", res_data, sb_q[0]);
        rst = 1'b1;
        step();
        chk("rb_res_vld", res_vld, 0);
        chk("rb_busy0", busy, 0);
        chk("rb_data0", res_data, 0);
        chk("rb_done0", drain_done, 0);
        chk("rb_ovf0", ovf, 0);
        chk("rb_down0", {out_down_TT, out_down_vld}, 0);
        rst = 1'b0;
        sb_q.delete();
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rb_no_done", {drain_done, busy}, 0);
        end
        for (int i = 0; i < NP; i++) sb_q.push_back(16'd0);
        drain_full();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
